// File: rtl/cos_result_fifo.sv
// Result buffer behind the cos(x) datapath: captures each final result with a
// wrapping sequence tag and hands it to the host through a valid/ready port.
module cos_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int TW    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_done_cap,
  input  logic [DW-1:0]            i_cos_bus,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DW-1:0]            o_out_data,
  output logic [TW-1:0]            o_out_tag,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop_err,
  input  logic                     i_clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TW + DW;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic [TW-1:0] r_tag_cnt;
  logic          r_drop_err;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  // Status flags come only from registered occupancy, never from this cycle's handshake.
  assign o_empty     = (r_level == '0);
  assign o_full      = (r_level == LW'(DEPTH));
  assign o_out_valid = ~o_empty;
  assign o_level     = r_level;
  assign o_drop_err  = r_drop_err;

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_pop  = o_out_valid & i_out_ready;
  assign w_push = i_done_cap & (~o_full | w_pop);
  assign w_drop = i_done_cap & o_full & ~w_pop;

  assign w_head     = r_mem[r_rd_ptr];
  assign o_out_data = w_head[DW-1:0];
  assign o_out_tag  = w_head[EW-1:DW];

  // Storage is cleared on reset so the head reads as zero until the first capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {r_tag_cnt, i_cos_bus};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Every capture strobe consumes a tag, so a dropped result shows up as a gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_cnt <= '0;
    end else if (i_done_cap) begin
      r_tag_cnt <= r_tag_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_err <= 1'b0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
    end else if (i_clr_err) begin
      r_drop_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cos_result_fifo.sv
// Directed and randomized bench for cos_result_fifo, checked against a
// queue-based model of the result buffer.
module tb_cos_result_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int TW    = 4;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          doneCap;
  logic [DW-1:0] cosBus;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [TW-1:0] outTag;
  logic          full;
  logic          empty;
  logic [2:0]    level;
  logic          dropErr;
  logic          clrErr;

  int checks = 0;
  int errors = 0;

  entry_t modelQ[$];
  int     modelTag     = 0;
  logic   modelDropErr = 1'b0;
  logic   modelMemZero = 1'b0;
  int     popIdx       = 0;

  cos_result_fifo #(.DEPTH(DEPTH), .DW(DW), .TW(TW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_done_cap  (doneCap),
    .i_cos_bus   (cosBus),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_out_tag   (outTag),
    .o_full      (full),
    .o_empty     (empty),
    .o_level     (level),
    .o_drop_err  (dropErr),
    .i_clr_err   (clrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Model one clock edge from the rules: queue order, tag per strobe, sticky drop flag.
  task automatic modelStep(input logic cap, input logic [DW-1:0] data, input logic ready,
                           input logic clr, input logic rstIn);
    bit     popNow;
    bit     pushNow;
    bit     dropNow;
    entry_t e;
    if (rstIn) begin
      modelQ.delete();
      modelTag     = 0;
      modelDropErr = 1'b0;
      modelMemZero = 1'b1;
      return;
    end
    popNow  = (modelQ.size() > 0) && ready;
    pushNow = cap && ((modelQ.size() < DEPTH) || popNow);
    dropNow = cap && (modelQ.size() == DEPTH) && !popNow;
    if (popNow) void'(modelQ.pop_front());
    if (pushNow) begin
      e.tag  = TW'(modelTag);
      e.data = data;
      modelQ.push_back(e);
      modelMemZero = 1'b0;
    end
    if (cap) modelTag = (modelTag + 1) % (1 << TW);
    if (dropNow) modelDropErr = 1'b1;
    else if (clr) modelDropErr = 1'b0;
  endtask

  task automatic checkOutput(input string step);
    check({step, " valid"}, 32'(outValid), 32'(modelQ.size() != 0));
    check({step, " empty"}, 32'(empty), 32'(modelQ.size() == 0));
    check({step, " full"}, 32'(full), 32'(modelQ.size() == DEPTH));
    check({step, " level"}, 32'(level), 32'(modelQ.size()));
    check({step, " drop_err"}, 32'(dropErr), 32'(modelDropErr));
    if (modelQ.size() != 0) begin
      check({step, " data"}, 32'(outData), 32'(modelQ[0].data));
      check({step, " tag"}, 32'(outTag), 32'(modelQ[0].tag));
    end else if (modelMemZero) begin
      check({step, " data0"}, 32'(outData), 32'h0);
      check({step, " tag0"}, 32'(outTag), 32'h0);
    end
  endtask

  task automatic applyStimulus(input string step, input logic cap, input logic [DW-1:0] data,
                               input logic ready, input logic clr, input logic rstIn);
    doneCap  = cap;
    cosBus   = data;
    outReady = ready;
    clrErr   = clr;
    rst      = rstIn;
    modelStep(cap, data, ready, clr, rstIn);
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    rst      = 1'b1;
    doneCap  = 1'b0;
    cosBus   = '0;
    outReady = 1'b0;
    clrErr   = 1'b0;

    // T1: reset held with a capture strobe present
    applyStimulus("T1", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    applyStimulus("T1", 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    check("T1 empty", 32'(empty), 32'h1);
    check("T1 level", 32'(level), 32'h0);

    // T2: single result held while not ready, then drained
    applyStimulus("T2", 1'b1, 16'h7FF0, 1'b0, 1'b0, 1'b0);
    check("T2 valid", 32'(outValid), 32'h1);
    check("T2 data", 32'(outData), 32'h7FF0);
    check("T2 tag", 32'(outTag), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("T2 hold", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("T2 hold data", 32'(outData), 32'h7FF0);
    end
    applyStimulus("T2 pop", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("T2 empty", 32'(empty), 32'h1);

    // T3: fill, overflow drop, ordered drain, tag gap
    applyStimulus("T3 rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("T3 fill", 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    end
    check("T3 full", 32'(full), 32'h1);
    check("T3 level", 32'(level), 32'h4);
    applyStimulus("T3 drop", 1'b1, 16'h0104, 1'b0, 1'b0, 1'b0);
    check("T3 drop_err", 32'(dropErr), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("T3 drain tag", 32'(outTag), 32'(i));
      check("T3 drain data", 32'(outData), 32'h0100 + 32'(i));
      applyStimulus("T3 drain", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus("T3 next", 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    check("T3 next tag", 32'(outTag), 32'h5);
    applyStimulus("T3 pop", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("T3 clr", 32'(dropErr), 32'h0);

    // T4: simultaneous push and pop at full and at level 1
    for (int i = 0; i < 4; i++) begin
      applyStimulus("T4 fill", 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus("T4 both", 1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    check("T4 level full", 32'(level), 32'h4);
    check("T4 no drop", 32'(dropErr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("T4 drain", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus("T4 both1", 1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    check("T4 level one", 32'(level), 32'h1);
    applyStimulus("T4 drain", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // T5: tag and pointer wrap with interleaved pops
    applyStimulus("T5 rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    popIdx = 0;
    for (int i = 0; i < 21; i++) begin
      logic rdy;
      rdy = outValid;
      if (rdy) begin
        check("T5 pop tag", 32'(outTag), 32'(popIdx % 16));
        popIdx++;
      end
      applyStimulus("T5", (i < 20), 16'($urandom), rdy, 1'b0, 1'b0);
      check("T5 level bound", 32'(level <= 3'd2), 32'h1);
    end
    check("T5 pop count", 32'(popIdx), 32'd20);

    // Randomized traffic including occasional clears and resets
    for (int i = 0; i < 300; i++) begin
      applyStimulus("RND", 1'($urandom_range(0, 1)), 16'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 99) == 0));
    end

    // T6: set beats clear, clear alone, mid-stream reset
    applyStimulus("T6 rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("T6 fill", 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus("T6 drop", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    check("T6 set", 32'(dropErr), 32'h1);
    applyStimulus("T6 drop+clr", 1'b1, 16'h1235, 1'b0, 1'b1, 1'b0);
    check("T6 set wins", 32'(dropErr), 32'h1);
    applyStimulus("T6 clr", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("T6 cleared", 32'(dropErr), 32'h0);
    applyStimulus("T6 pop", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("T6 level3", 32'(level), 32'h3);
    applyStimulus("T6 rst", 1'b1, 16'h4321, 1'b0, 1'b0, 1'b1);
    check("T6 empty", 32'(empty), 32'h1);
    applyStimulus("T6 cap", 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check("T6 tag restart", 32'(outTag), 32'h0);
    check("T6 data", 32'(outData), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
